// File: rtl/clk_gate_sequencer.sv
// Clock-gate enable sequencer: staggered round-robin wake-up, idle auto-gating, DFT override.
// Optional wake counter on wake_cnt_o when CLK_GATE_SEQ_WAKE_CNT_EN is defined.
module clk_gate_sequencer #(
   parameter int unsigned NumDomains    = 4,
   parameter int unsigned IdleCycles    = 16,
   parameter int unsigned StaggerCycles = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  test_en_i,
   input  logic [NumDomains-1:0] req_i,
   input  logic [NumDomains-1:0] busy_i,
   output logic [NumDomains-1:0] en_o,
   output logic [NumDomains-1:0] ack_o
`ifdef CLK_GATE_SEQ_WAKE_CNT_EN
   ,
   output logic [31:0]           wake_cnt_o
`endif
);

   localparam int unsigned CntW = $clog2(IdleCycles + 1);
   localparam int unsigned PtrW = (NumDomains > 1) ? $clog2(NumDomains) : 1;
   localparam int unsigned CdW  = (StaggerCycles > 1) ? $clog2(StaggerCycles) : 1;

`ifndef SYNTHESIS
   if (NumDomains < 1) begin : g_chk_domains
      $error("NumDomains must be >= 1");
   end
   if (IdleCycles < 1) begin : g_chk_idle
      $error("IdleCycles must be >= 1");
   end
   if (StaggerCycles < 1) begin : g_chk_stagger
      $error("StaggerCycles must be >= 1");
   end
`endif

   typedef enum logic [1:0] {
      StOff,
      StPend,
      StEn,
      StOn
   } state_e;

   state_e                state_q    [NumDomains];
   state_e                state_d    [NumDomains];
   logic [CntW-1:0]       idle_cnt_q [NumDomains];
   logic [CntW-1:0]       idle_cnt_d [NumDomains];
   logic [PtrW-1:0]       rr_ptr_q, rr_ptr_d;
   logic [CdW-1:0]        cooldown_q, cooldown_d;
   logic [NumDomains-1:0] pend, en_dec, ack_dec, grant;
   logic                  grant_vld;
   logic [PtrW-1:0]       grant_idx;
   logic [PtrW-1:0]       arb_idx;

   // State decode kept separate from next-state logic so pend->grant->state_d stays acyclic.
   always_comb begin
      pend    = '0;
      en_dec  = '0;
      ack_dec = '0;
      for (int unsigned d = 0; d < NumDomains; d++) begin
         pend[d]    = (state_q[d] == StPend);
         en_dec[d]  = (state_q[d] == StEn) || (state_q[d] == StOn);
         ack_dec[d] = (state_q[d] == StOn);
      end
   end

   always_comb begin
      grant      = '0;
      grant_vld  = 1'b0;
      grant_idx  = '0;
      arb_idx    = '0;
      rr_ptr_d   = rr_ptr_q;
      cooldown_d = cooldown_q;
      if (cooldown_q == '0) begin
         for (int unsigned i = 0; i < NumDomains; i++) begin
            arb_idx = PtrW'((32'(rr_ptr_q) + i) % NumDomains);
            if (!grant_vld && pend[arb_idx]) begin
               grant_vld      = 1'b1;
               grant_idx      = arb_idx;
               grant[arb_idx] = 1'b1;
            end
         end
      end
      if (grant_vld) begin
         rr_ptr_d   = PtrW'((32'(grant_idx) + 1) % NumDomains);
         cooldown_d = CdW'(StaggerCycles - 1);
      end else if (cooldown_q != '0) begin
         cooldown_d = cooldown_q - 1'b1;
      end
   end

   always_comb begin
      for (int unsigned d = 0; d < NumDomains; d++) begin
         state_d[d]    = state_q[d];
         idle_cnt_d[d] = '0;
         case (state_q[d])
            StOff:  if (req_i[d]) state_d[d] = StPend;
            StPend: begin
               if (grant[d])    state_d[d] = StEn;
               else if (!req_i[d]) state_d[d] = StOff;
            end
            StEn:   state_d[d] = StOn;
            StOn: begin
               if (req_i[d] || busy_i[d]) begin
                  idle_cnt_d[d] = '0;
               end else if (idle_cnt_q[d] == CntW'(IdleCycles - 1)) begin
                  state_d[d] = StOff;
               end else if (idle_cnt_q[d] != '1) begin
                  idle_cnt_d[d] = idle_cnt_q[d] + 1'b1;
               end else begin
                  idle_cnt_d[d] = idle_cnt_q[d];
               end
            end
            default: state_d[d] = StOff;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int unsigned d = 0; d < NumDomains; d++) begin
            state_q[d]    <= StOff;
            idle_cnt_q[d] <= '0;
         end
         rr_ptr_q   <= '0;
         cooldown_q <= '0;
      end else begin
         for (int unsigned d = 0; d < NumDomains; d++) begin
            state_q[d]    <= state_d[d];
            idle_cnt_q[d] <= idle_cnt_d[d];
         end
         rr_ptr_q   <= rr_ptr_d;
         cooldown_q <= cooldown_d;
      end
   end

`ifdef CLK_GATE_SEQ_WAKE_CNT_EN
   logic [31:0] wake_cnt_q, wake_cnt_d;

   always_comb begin
      wake_cnt_d = wake_cnt_q + {31'd0, grant_vld};
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) wake_cnt_q <= '0;
      else       wake_cnt_q <= wake_cnt_d;
   end

   assign wake_cnt_o = wake_cnt_q;
`endif

   assign en_o  = test_en_i ? '1 : en_dec;
   assign ack_o = ack_dec;

endmodule

// File: tb/tb_clk_gate_sequencer.sv
// Directed self-checking bench for clk_gate_sequencer (NumDomains=4, IdleCycles=16, StaggerCycles=4).
module tb_clk_gate_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        test_en;
   logic [3:0]  req, busy, en, ack;
`ifdef CLK_GATE_SEQ_WAKE_CNT_EN
   logic [31:0] wake_cnt;
`endif
   int          tests = 0;
   int          fails = 0;
   logic [3:0]  exp_en, exp_ack;

   always #5 clk = ~clk;

   clk_gate_sequencer #(
      .NumDomains   (4),
      .IdleCycles   (16),
      .StaggerCycles(4)
   ) dut (
      .clk_i     (clk),
      .rst_i     (rst),
      .test_en_i (test_en),
      .req_i     (req),
      .busy_i    (busy),
      .en_o      (en),
      .ack_o     (ack)
`ifdef CLK_GATE_SEQ_WAKE_CNT_EN
      ,
      .wake_cnt_o(wake_cnt)
`endif
   );

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1; test_en = 1'b0; req = '0; busy = '0;
      step(2);
      check("reset_en", en, 4'b0000);
      check("reset_ack", ack, 4'b0000);

      // Single wake and idle timeout
      rst = 1'b0; req = 4'b0001;
      step(1); check("t1_pend_en", en, 4'b0000);
      step(1); check("t1_en", en, 4'b0001); check("t1_ack_lo", ack, 4'b0000);
      step(1); check("t1_ack", ack, 4'b0001);
      step(5); check("t1_hold", en, 4'b0001);
      req = '0;
      step(15); check("t1_idle15", en, 4'b0001);
      step(1); check("t1_off_en", en, 4'b0000); check("t1_off_ack", ack, 4'b0000);

      // Staggered wake of all domains from a fresh reset
      rst = 1'b1; step(1); rst = 1'b0;
      req = 4'b1111;
      for (int e = 1; e <= 15; e++) begin
         step(1);
         exp_en = '0; exp_ack = '0;
         for (int k = 0; k < 4; k++) begin
            if (e >= 2 + 4 * k) exp_en[k] = 1'b1;
            if (e >= 3 + 4 * k) exp_ack[k] = 1'b1;
         end
         check($sformatf("t2_en_e%0d", e), en, exp_en);
         check($sformatf("t2_ack_e%0d", e), ack, exp_ack);
      end
`ifdef CLK_GATE_SEQ_WAKE_CNT_EN
      tests++;
      assert (wake_cnt === 32'd4)
      else begin
         fails++;
         $error("FAIL t2_wake_cnt: observed %0d expected 4", wake_cnt);
      end
`endif

      // Reset with all domains on
      rst = 1'b1; req = '0;
      step(1);
      check("rst_all_on_en", en, 4'b0000);
      check("rst_all_on_ack", ack, 4'b0000);
`ifdef CLK_GATE_SEQ_WAKE_CNT_EN
      tests++;
      assert (wake_cnt === 32'd0)
      else begin
         fails++;
         $error("FAIL rst_wake_cnt: observed %0d expected 0", wake_cnt);
      end
`endif
      rst = 1'b0;

      // DFT override
      test_en = 1'b1; #1;
      check("test_en_en", en, 4'b1111);
      check("test_en_ack", ack, 4'b0000);
      step(2);
      check("test_en_hold", en, 4'b1111);
      test_en = 1'b0; #1;
      check("test_en_rel", en, 4'b0000);

      // Round-robin fairness
      req = 4'b0110;
      step(1); check("rr_pend", en, 4'b0000);
      step(1); check("rr_first_d1", en, 4'b0010);
      step(3); check("rr_cooldown", en, 4'b0010);
      step(1); check("rr_then_d2", en, 4'b0110);
      req = 4'b0100;
      step(15); check("rr_d1_idle15", en, 4'b0110);
      step(1); check("rr_d1_off", en, 4'b0100);
      req = 4'b1110;
      step(1); check("rr2_pend", en, 4'b0100);
      step(1); check("rr2_d3_first", en, 4'b1100);
      step(4); check("rr2_d1_next", en, 4'b1110);
      step(1); check("rr2_ack", ack, 4'b1110);

      // Busy in the exact timeout cycle restarts the idle count
      req = 4'b1010;
      step(15); check("race_pre", en, 4'b1110);
      busy = 4'b0100;
      step(1); check("race_en", en, 4'b1110); check("race_ack", ack, 4'b1110);
      busy = '0;
      step(15); check("race_restart15", en, 4'b1110);
      step(1); check("race_off_en", en, 4'b1010); check("race_off_ack", ack, 4'b1010);

      // Pending request cancelled while cooldown is running
      req = 4'b1011;
      step(1); check("cancel_pend0", en, 4'b1010);
      step(1); check("cancel_grant0", en, 4'b1011); check("cancel_ack_lo", ack, 4'b1010);
      req = 4'b1111;
      step(1); check("cancel_d2_pend", en, 4'b1011);
      req = 4'b1011;
      step(1); check("cancel_d2_off", en, 4'b1011);
      step(4); check("cancel_no_wake_en", en, 4'b1011); check("cancel_no_wake_ack", ack, 4'b1011);

      // Reset mid-operation
      rst = 1'b1;
      step(1);
      check("rst_mid_en", en, 4'b0000);
      check("rst_mid_ack", ack, 4'b0000);
      rst = 1'b0; req = '0;
      step(1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
